// File: rtl/clap_pkg.sv
// Shared definitions for the clap sequence counter: FSM encoding and default timing
// constants for a 100 MHz system clock.
package clap_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOCKOUT = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_REPORT  = 2'd3;

  // 50 ms lockout, 500 ms inter-clap window at 100 MHz
  localparam int DEFAULT_LOCKOUT_CYCLES = 5_000_000;
  localparam int DEFAULT_WINDOW_CYCLES  = 50_000_000;
  localparam int DEFAULT_COUNT_W        = 4;

endpackage

// File: rtl/clap_edge_detect.sv
// Rising-edge detector: registers the previous sample and flags 0->1 transitions
// combinationally against the current input.
module clap_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= RESET_VAL;
    else     prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/clap_sequence_counter.sv
// Counts debounced claps, groups them into sequences bounded by an inter-clap window,
// and reports each finished sequence's count with a one-cycle valid pulse.
module clap_sequence_counter
  import clap_pkg::*;
#(
  parameter int COUNT_W        = DEFAULT_COUNT_W,
  parameter int LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES,
  parameter int WINDOW_CYCLES  = DEFAULT_WINDOW_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ledPeak,
  output logic [COUNT_W-1:0] clapCount,
  output logic [COUNT_W-1:0] seqCount,
  output logic               seqValid,
  output logic               busy
);

  localparam int TMAX = (LOCKOUT_CYCLES > WINDOW_CYCLES) ? LOCKOUT_CYCLES : WINDOW_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] WIN_LAST  = TW'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] ONE  = COUNT_W'(1);

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [COUNT_W-1:0] clap_q, clap_d;
  logic [COUNT_W-1:0] seq_q, seq_d;
  logic               vld_q, vld_d;
  logic               clap_edge;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (&c) ? c : c + ONE;
  endfunction

  // Previous sample resets high so a peak held across reset release is not a clap
  clap_edge_detect #(.RESET_VAL(1'b1)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (ledPeak),
    .rise_o (clap_edge)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    clap_d  = clap_q;
    seq_d   = seq_q;
    case (state_q)
      ST_IDLE: begin
        if (clap_edge) begin
          clap_d  = ONE;
          timer_d = '0;
          state_d = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // A clap on the window's last cycle still extends the sequence
        if (clap_edge) begin
          clap_d  = sat_inc(clap_q);
          timer_d = '0;
          state_d = ST_LOCKOUT;
        end else if (timer_q == WIN_LAST) begin
          seq_d   = clap_q;
          state_d = ST_REPORT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        if (clap_edge) begin
          clap_d  = ONE;
          timer_d = '0;
          state_d = ST_LOCKOUT;
        end else begin
          clap_d  = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
    vld_d = (state_d == ST_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      clap_q  <= '0;
      seq_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      clap_q  <= clap_d;
      seq_q   <= seq_d;
      vld_q   <= vld_d;
    end
  end

  assign clapCount = clap_q;
  assign seqCount  = seq_q;
  assign seqValid  = vld_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clap_sequence_counter.sv
// Directed bench for clap_sequence_counter with COUNT_W=3, LOCKOUT_CYCLES=4, WINDOW_CYCLES=10.
module tb_clap_sequence_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ledPeak = 1'b0;
  logic [2:0] clapCount;
  logic [2:0] seqCount;
  logic       seqValid;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic [2:0] last_seq = '0;

  clap_sequence_counter #(
    .COUNT_W        (3),
    .LOCKOUT_CYCLES (4),
    .WINDOW_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ledPeak   (ledPeak),
    .clapCount (clapCount),
    .seqCount  (seqCount),
    .seqValid  (seqValid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (seqValid) begin
      pulses   <= pulses + 1;
      last_seq <= seqCount;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 40) begin
      step(1);
      k++;
    end
    step(1);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_timeout: busy=%0b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    step(2);
    vectors++;
    if ({clapCount, seqCount, seqValid, busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: clap=%0d seq=%0d vld=%0b busy=%0b required all 0",
               clapCount, seqCount, seqValid, busy);
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    int base;
    base = pulses;
    ledPeak = 1'b1;
    step(1);
    vectors++;
    if (clapCount !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_first: clap=%0d busy=%0b required 1/1", clapCount, busy);
    end
    step(1);
    ledPeak = 1'b0;
    step(12);
    vectors++;
    if (seqValid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: seqValid=%0b required 0", seqValid);
    end
    step(1);
    vectors++;
    if (seqValid !== 1'b1 || seqCount !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_report: vld=%0b seq=%0d busy=%0b required 1/1/1",
               seqValid, seqCount, busy);
    end
    step(1);
    vectors++;
    if (clapCount !== 3'd0 || busy !== 1'b0 || seqValid !== 1'b0 || seqCount !== 3'd1) begin
      miscompares++;
      $display("FAIL single_after: clap=%0d busy=%0b vld=%0b seq=%0d required 0/0/0/1",
               clapCount, busy, seqValid, seqCount);
    end
    vectors++;
    if (pulses - base !== 1) begin
      miscompares++;
      $display("FAIL single_pulses: got %0d required 1", pulses - base);
    end
  endtask

  task automatic test_bounce();
    int base;
    base = pulses;
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0; step(1);
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0; step(1);
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0;
    vectors++;
    if (clapCount !== 3'd1) begin
      miscompares++;
      $display("FAIL bounce_count: clap=%0d required 1", clapCount);
    end
    wait_idle("bounce");
    vectors++;
    if (pulses - base !== 1 || last_seq !== 3'd1) begin
      miscompares++;
      $display("FAIL bounce_report: pulses=%0d seq=%0d required 1/1", pulses - base, last_seq);
    end
  endtask

  task automatic test_triple();
    int base;
    base = pulses;
    for (int k = 1; k <= 3; k++) begin
      ledPeak = 1'b1;
      step(1);
      ledPeak = 1'b0;
      vectors++;
      if (clapCount !== 3'(k)) begin
        miscompares++;
        $display("FAIL triple_step%0d: clap=%0d required %0d", k, clapCount, k);
      end
      if (k < 3) step(7);
    end
    vectors++;
    if (pulses - base !== 0) begin
      miscompares++;
      $display("FAIL triple_intermediate: pulses=%0d required 0", pulses - base);
    end
    wait_idle("triple");
    vectors++;
    if (pulses - base !== 1 || last_seq !== 3'd3) begin
      miscompares++;
      $display("FAIL triple_report: pulses=%0d seq=%0d required 1/3", pulses - base, last_seq);
    end
  endtask

  task automatic test_saturation();
    int base;
    base = pulses;
    for (int k = 1; k <= 9; k++) begin
      ledPeak = 1'b1;
      step(1);
      ledPeak = 1'b0;
      if (k >= 6) begin
        vectors++;
        if (clapCount !== ((k > 7) ? 3'd7 : 3'(k))) begin
          miscompares++;
          $display("FAIL sat_clap%0d: clap=%0d required %0d", k, clapCount, (k > 7) ? 7 : k);
        end
      end
      if (k < 9) step(5);
    end
    wait_idle("sat");
    vectors++;
    if (pulses - base !== 1 || last_seq !== 3'd7) begin
      miscompares++;
      $display("FAIL sat_report: pulses=%0d seq=%0d required 1/7", pulses - base, last_seq);
    end
  endtask

  task automatic test_edge_at_expiry();
    int base;
    base = pulses;
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0; step(13);
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0;
    vectors++;
    if (clapCount !== 3'd2 || seqValid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL expiry_edge: clap=%0d vld=%0b busy=%0b required 2/0/1",
               clapCount, seqValid, busy);
    end
    wait_idle("expiry");
    vectors++;
    if (pulses - base !== 1 || last_seq !== 3'd2) begin
      miscompares++;
      $display("FAIL expiry_report: pulses=%0d seq=%0d required 1/2", pulses - base, last_seq);
    end
  endtask

  task automatic test_edge_in_report();
    int base;
    base = pulses;
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0; step(14);
    vectors++;
    if (seqValid !== 1'b1 || seqCount !== 3'd1) begin
      miscompares++;
      $display("FAIL report_cycle: vld=%0b seq=%0d required 1/1", seqValid, seqCount);
    end
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0;
    vectors++;
    if (clapCount !== 3'd1 || busy !== 1'b1 || seqValid !== 1'b0) begin
      miscompares++;
      $display("FAIL report_edge: clap=%0d busy=%0b vld=%0b required 1/1/0",
               clapCount, busy, seqValid);
    end
    wait_idle("report_edge");
    vectors++;
    if (pulses - base !== 2 || last_seq !== 3'd1) begin
      miscompares++;
      $display("FAIL report_followup: pulses=%0d seq=%0d required 2/1", pulses - base, last_seq);
    end
  endtask

  task automatic test_reset_mid_wait();
    int base;
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0; step(7);
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0; step(5);
    vectors++;
    if (clapCount !== 3'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midwait_pre: clap=%0d busy=%0b required 2/1", clapCount, busy);
    end
    base = pulses;
    rst = 1'b1; step(1);
    vectors++;
    if ({clapCount, seqCount, seqValid, busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL midwait_reset: clap=%0d seq=%0d vld=%0b busy=%0b required all 0",
               clapCount, seqCount, seqValid, busy);
    end
    rst = 1'b0;
    step(30);
    vectors++;
    if (pulses - base !== 0) begin
      miscompares++;
      $display("FAIL midwait_noreport: pulses=%0d required 0", pulses - base);
    end
  endtask

  task automatic test_held_through_reset();
    ledPeak = 1'b1;
    rst = 1'b1; step(2);
    rst = 1'b0; step(3);
    vectors++;
    if (clapCount !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL held_reset: clap=%0d busy=%0b required 0/0", clapCount, busy);
    end
    ledPeak = 1'b0; step(1);
    ledPeak = 1'b1; step(1);
    ledPeak = 1'b0;
    vectors++;
    if (clapCount !== 3'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL held_then_clap: clap=%0d busy=%0b required 1/1", clapCount, busy);
    end
    wait_idle("held");
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_triple();
    test_saturation();
    test_edge_at_expiry();
    test_edge_in_report();
    test_reset_mid_wait();
    test_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
